// File: rtl/game_controller_pkg.sv
// rtl/game_controller_pkg.sv - shared state encodings, defaults and widths for game_controller
package game_controller_pkg;

  typedef enum logic [1:0] {
    ST_SETUP = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam int DEF_TICK_DIV  = 50_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;
  localparam int GEN_W         = 16;

  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
    return (v == GEN_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_controller_btn_debounce.sv
// rtl/game_controller_btn_debounce.sv - button synchronizer, debouncer and press pulse
module btn_debounce
  import game_controller_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - setup/load/run/pause sequencer producing generation step pulses
module game_controller
  import game_controller_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BtnC,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic [1:0]  speed_sel,
  output logic        setup_enable,
  output logic        board_load,
  output logic        step,
  output logic [15:0] gen_count,
  output logic [1:0]  state_led
);

  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam logic [TW-1:0] TICK_DIV_W = TW'(TICK_DIV);

  state_t           state;
  state_t           state_d;
  logic             step_d;
  logic             wrap;
  logic             press_l;
  logic             press_c;
  logic             press_r;
  logic             evt_l;
  logic             evt_c;
  logic             evt_r;
  logic [TW-1:0]    tick;
  logic [TW-1:0]    period_q;
  logic [TW-1:0]    period_sel;
  logic [TW-1:0]    period_m1;
  logic [GEN_W-1:0] gen_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (.clk(clk), .rst_n(rst_n), .btn(BtnL), .press(press_l));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (.clk(clk), .rst_n(rst_n), .btn(BtnC), .press(press_c));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (.clk(clk), .rst_n(rst_n), .btn(BtnR), .press(press_r));

  // Coincident presses: only the highest-priority one survives
  assign evt_l = press_l;
  assign evt_c = press_c & ~press_l;
  assign evt_r = press_r & ~press_l & ~press_c;

  assign period_sel = TICK_DIV_W >> speed_sel;
  assign period_m1  = (period_q == '0) ? '0 : period_q - 1'b1;
  // >= rather than == so a shrinking period never leaves the counter stranded above it
  assign wrap       = (state == ST_RUN) && (tick >= period_m1);

  assign state_led = state;
  assign gen_count = gen_q;

  always_comb begin
    state_d = state;
    step_d  = 1'b0;
    case (state)
      ST_SETUP: begin
        if (evt_r) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        step_d = wrap;
        if (evt_l)      state_d = ST_SETUP;
        else if (evt_c) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (evt_l)      state_d = ST_SETUP;
        else if (evt_c) state_d = ST_RUN;
        else if (evt_r) step_d  = 1'b1;
      end
      default: state_d = ST_SETUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SETUP;
      setup_enable <= 1'b1;
      board_load   <= 1'b0;
      step         <= 1'b0;
      gen_q        <= '0;
      tick         <= '0;
      period_q     <= TICK_DIV_W;
    end else begin
      state        <= state_d;
      setup_enable <= (state_d == ST_SETUP);
      board_load   <= (state_d == ST_LOAD);
      step         <= step_d;

      if (state_d == ST_LOAD) gen_q <= '0;
      else if (step_d)        gen_q <= sat_inc(gen_q);

      // Counter restarts on every entry to RUN and idles at zero elsewhere
      if (state == ST_RUN && state_d == ST_RUN) tick <= wrap ? '0 : tick + 1'b1;
      else                                      tick <= '0;

      // Speed changes are sampled only at a wrap while running
      if (state != ST_RUN || wrap) period_q <= period_sel;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// tb/tb_game_controller.sv - directed table-driven bench for game_controller
module tb_game_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        BtnC, BtnL, BtnR;
  logic [1:0]  speed_sel;
  logic        setup_enable, board_load, step;
  logic [15:0] gen_count;
  logic [1:0]  state_led;

  int total = 0;
  int bad   = 0;
  int n_step;
  int n_load;

  typedef struct {
    logic [2:0] btn;
    int         hold;
    int         idle;
    logic [1:0] spd;
    logic [1:0] e_state;
    int         e_gen;
    int         e_steps;
    int         e_loads;
  } vec_t;

  vec_t tbl[12];

  game_controller #(.TICK_DIV(16), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .BtnC(BtnC), .BtnL(BtnL), .BtnR(BtnR),
    .speed_sel(speed_sel), .setup_enable(setup_enable), .board_load(board_load),
    .step(step), .gen_count(gen_count), .state_led(state_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [2:0] b);
    BtnL = b[2];
    BtnC = b[1];
    BtnR = b[0];
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_step += int'(step);
      n_load += int'(board_load);
    end
  endtask

  task automatic press(input logic [2:0] b, input int hold, input int idle);
    set_btn(b);
    run_cycles(hold);
    set_btn(3'b000);
    run_cycles(idle);
  endtask

  task automatic wait_step(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (step) return;
    end
    cyc = -1;
  endtask

  int c;
  int k;

  initial begin
    tbl[0]  = '{3'b001, 10, 10,  2'd0, 2'b10, 0,  0, 1};
    tbl[1]  = '{3'b000,  0, 64,  2'd0, 2'b10, 4,  4, 0};
    tbl[2]  = '{3'b010, 10, 10,  2'd0, 2'b11, 5,  1, 0};
    tbl[3]  = '{3'b000,  0, 100, 2'd0, 2'b11, 5,  0, 0};
    tbl[4]  = '{3'b001, 10, 10,  2'd0, 2'b11, 6,  1, 0};
    tbl[5]  = '{3'b001, 10, 10,  2'd0, 2'b11, 7,  1, 0};
    tbl[6]  = '{3'b001, 10, 10,  2'd0, 2'b11, 8,  1, 0};
    tbl[7]  = '{3'b010, 10, 10,  2'd0, 2'b10, 8,  0, 0};
    tbl[8]  = '{3'b000,  0, 64,  2'd0, 2'b10, 12, 4, 0};
    tbl[9]  = '{3'b100, 10, 10,  2'd0, 2'b00, 13, 1, 0};
    tbl[10] = '{3'b010, 10, 10,  2'd0, 2'b00, 13, 0, 0};
    tbl[11] = '{3'b001, 10, 10,  2'd0, 2'b10, 0,  0, 1};

    rst_n = 1'b0;
    set_btn(3'b000);
    speed_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_led), 32'd0);
    chk("rst_setup_en", 32'(setup_enable), 32'd1);
    chk("rst_board_load", 32'(board_load), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      n_step = 0;
      n_load = 0;
      speed_sel = tbl[i].spd;
      press(tbl[i].btn, tbl[i].hold, tbl[i].idle);
      chk($sformatf("v%0d_state", i), 32'(state_led), 32'(tbl[i].e_state));
      chk($sformatf("v%0d_gen", i), 32'(gen_count), 32'(tbl[i].e_gen));
      chk($sformatf("v%0d_steps", i), 32'(n_step), 32'(tbl[i].e_steps));
      chk($sformatf("v%0d_loads", i), 32'(n_load), 32'(tbl[i].e_loads));
      chk($sformatf("v%0d_setup_en", i), 32'(setup_enable), 32'(tbl[i].e_state == 2'b00));
    end

    // step spacing at speed 0, then speed 2 after the next wrap
    wait_step(40, c);
    chk("sync0_timeout", 32'(c > 0), 32'd1);
    wait_step(40, c);
    chk("period16", 32'(c), 32'd16);
    speed_sel = 2'd2;
    wait_step(40, c);
    chk("sync2_timeout", 32'(c > 0), 32'd1);
    wait_step(40, c);
    chk("period4_a", 32'(c), 32'd4);
    wait_step(40, c);
    chk("period4_b", 32'(c), 32'd4);

    // short glitch on BtnC must not change state
    press(3'b010, 2, 12);
    chk("glitch_state", 32'(state_led), 32'd2);

    // BtnL wins over BtnC in the same cycle
    press(3'b110, 10, 10);
    chk("lc_state", 32'(state_led), 32'd0);
    chk("lc_setup_en", 32'(setup_enable), 32'd1);

    // saturation of gen_count
    speed_sel = 2'd3;
    press(3'b001, 10, 10);
    chk("sat_run_state", 32'(state_led), 32'd2);
    @(negedge clk);
    force dut.gen_q = 16'hFFFE;
    @(negedge clk);
    release dut.gen_q;
    n_step = 0;
    run_cycles(10);
    chk("sat_steps_seen", 32'(n_step > 1), 32'd1);
    chk("sat_gen", 32'(gen_count), 32'hFFFF);
    run_cycles(10);
    chk("sat_gen_hold", 32'(gen_count), 32'hFFFF);

    // asynchronous reset mid-RUN
    #1 rst_n = 1'b0;
    #1;
    chk("mrun_state", 32'(state_led), 32'd0);
    chk("mrun_setup_en", 32'(setup_enable), 32'd1);
    chk("mrun_step", 32'(step), 32'd0);
    chk("mrun_board_load", 32'(board_load), 32'd0);
    chk("mrun_gen", 32'(gen_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_step = 0;
    n_load = 0;
    run_cycles(40);
    chk("mrun_post_steps", 32'(n_step), 32'd0);
    chk("mrun_post_state", 32'(state_led), 32'd0);

    // asynchronous reset while in LOAD
    speed_sel = 2'd0;
    BtnR = 1'b1;
    k = 0;
    while (k < 20 && !board_load) begin
      @(negedge clk);
      k++;
    end
    chk("mload_seen", 32'(board_load), 32'd1);
    BtnR = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mload_board_load", 32'(board_load), 32'd0);
    chk("mload_state", 32'(state_led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_step = 0;
    n_load = 0;
    run_cycles(30);
    chk("mload_post_loads", 32'(n_load), 32'd0);
    chk("mload_post_steps", 32'(n_step), 32'd0);
    chk("mload_post_state", 32'(state_led), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clock cycles per generation at speed_sel=0.
REQ-002 Parameter DB_CYCLES, default 1_000_000, consecutive stable cycles required to accept a button press.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 BtnC  input  1  raw button, asynchronous; run/pause toggle.
REQ-006 BtnL  input  1  raw button, asynchronous; return to setup.
REQ-007 BtnR  input  1  raw button, asynchronous; start from setup / single-step while paused.
REQ-008 speed_sel  input  2  generation rate select.
REQ-009 setup_enable  output  1  high while board editing is permitted (drives the editor's enable).
REQ-010 board_load  output  1  one-cycle pulse: engine copies the edited board.
REQ-011 step  output  1  one-cycle pulse: engine computes one generation.
REQ-012 gen_count  output  16  generations stepped since last load.
REQ-013 state_led  output  2  current FSM state encoding.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose level changes only after DB_CYCLES consecutive identical synchronized samples.
REQ-015 Each debouncer SHALL emit a one-cycle press pulse on each 0->1 transition of its debounced level; holding a button yields exactly one pulse.
REQ-016 FSM states: SETUP=2'b00, LOAD=2'b01, RUN=2'b10, PAUSE=2'b11; state_led SHALL equal the state register.
REQ-017 Press pulses coinciding in one cycle SHALL be prioritized BtnL > BtnC > BtnR; lower-priority pulses are discarded.
REQ-018 SETUP: setup_enable=1; BtnR pulse -> LOAD; BtnC and BtnL ignored.
REQ-019 LOAD: lasts exactly one cycle; board_load=1 and gen_count cleared to 0 in that cycle; unconditional -> RUN.
REQ-020 RUN: tick counter increments each cycle; when it equals PERIOD-1 it wraps to 0 and step pulses for one cycle.
REQ-021 PERIOD = TICK_DIV >> speed_sel; a speed_sel change takes effect at the next wrap; a counter already above the new PERIOD-1 SHALL wrap at its own width (no hang) only if PERIOD >= 1; implementations SHALL instead force wrap immediately when counter >= PERIOD-1.
REQ-022 Tick counter SHALL reset to 0 on every entry to RUN; first step occurs PERIOD cycles after entry.
REQ-023 RUN: BtnC pulse -> PAUSE; BtnL pulse -> SETUP; BtnR ignored.
REQ-024 PAUSE: BtnC pulse -> RUN; BtnR pulse -> one step pulse in the same cycle, remain PAUSE; BtnL pulse -> SETUP.
REQ-025 A step pulse and a transition out of RUN in the same cycle: step still asserted (generation completes).
REQ-026 gen_count SHALL increment by 1 with every step pulse and saturate at 16'hFFFF.
REQ-027 setup_enable SHALL be 0 in LOAD, RUN, PAUSE; board_load and step never asserted in SETUP.
REQ-028 step, board_load and setup_enable are registered outputs (no combinational path from buttons).

Reset
REQ-029 rst_n low SHALL immediately force: state=SETUP, setup_enable=1, board_load=0, step=0, gen_count=0, tick counter=0, synchronizers/debouncers cleared (debounced level 0).
REQ-030 Reset asserted mid-RUN or mid-LOAD SHALL abort with no trailing step/board_load pulse after release.

Structure
REQ-031 Shared package holds state encodings, default TICK_DIV/DB_CYCLES, gen_count width.
REQ-032 One sub-module btn_debounce (synchronizer + debouncer + press pulse), instantiated three times.
REQ-033 Tick counter width SHALL be $clog2(TICK_DIV)+1 bits.

Verification (TICK_DIV=16, DB_CYCLES=4)
REQ-034 Reset, hold BtnR 10 cycles -> one board_load pulse, state 00->01->10, gen_count=0.
REQ-035 RUN, speed_sel=0, 64 cycles -> 4 step pulses 16 cycles apart, gen_count=4; speed_sel=2 -> pulses every 4 cycles after next wrap.
REQ-036 RUN, BtnC press -> PAUSE, no steps for 100 cycles; BtnR press x3 -> 3 step pulses, gen_count +3.
REQ-037 BtnC glitch high 2 cycles -> no state change; BtnL and BtnC pressed same cycle in RUN -> SETUP.
REQ-038 Force gen_count to 16'hFFFE, two steps -> 16'hFFFF held.
REQ-039 rst_n pulsed low mid-RUN -> outputs at reset values same cycle, state 00, no step after release.
